cam_capture_ctrl: RTL and testbench
===================================

Name: cam_capture_ctrl

Overview:
Sequences single-frame capture from the 8-bit parallel camera port (pclk/vsync/href/data) into a downstream frame-buffer writer. Oversamples all camera signals in the system clock domain, arms on shutter press or software request, frames on vsync and href, and packs byte pairs into RGB565 pixels. Emits each pixel with a linear frame-buffer address over a valid/ready handshake, and reports completion and overrun. Sits between the camera pins and the Avalon-side frame-buffer master in soc_system.

Parameters:
H_ACTIVE, 640, pixels per line written; extra pixels in a line are dropped
V_ACTIVE, 480, lines per frame written; capture ends after this many lines
ADDR_W, 19, width of pix_addr; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE
DEBOUNCE_CYCLES, 1000000, clk cycles the shutter must be stable to register a change
SYNC_STAGES, 2, synchroniser depth on all camera and shutter inputs

Ports:
clk  in  1  system clock; must be at least 4x cam_pclk
reset_n  in  1  asynchronous active-low reset
cam_pclk  in  1  camera pixel clock, sampled as data
cam_vsync  in  1  high during vertical blanking pulse
cam_href  in  1  high during active line bytes
cam_data  in  8  camera byte, valid on cam_pclk rising edge
shutter  in  1  raw shutter switch, active high
arm  in  1  single-cycle software capture request
clear_overflow  in  1  single-cycle clear for overflow
pix_data  out  16  RGB565 pixel, {first byte, second byte}
pix_addr  out  ADDR_W  line*H_ACTIVE + column
pix_valid  out  1  pixel available
pix_ready  in  1  downstream accepts when pix_valid && pix_ready
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse at end of frame
overflow  out  1  sticky: a pixel was lost to backpressure

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters, byte phase and debounce state cleared. Reset mid-frame abandons the frame with no frame_done.
- Input conditioning: pclk, vsync, href and data each pass through SYNC_STAGES flops. Data takes an extra stage so it aligns with the detected pclk edge. Edges come from the last stage versus a delay flop.
- Shutter debounce: the registered shutter level changes only after the raw input differs from it for DEBOUNCE_CYCLES consecutive clk cycles. A rising edge of the debounced level is a trigger.
- FSM:
  - IDLE: go to WAIT_VS on trigger or arm. A trigger in any other state is ignored.
  - WAIT_VS: go to CAPTURE on a vsync falling edge. A frame already in progress is never captured partially.
  - CAPTURE: see the bullets below. Go to FLUSH on a vsync rising edge, or when a line-end makes line == V_ACTIVE.
  - FLUSH: wait until pix_valid == 0, then pulse frame_done for one cycle and go to IDLE.
- In CAPTURE:
  - Byte phase resets to 0 on each href rising edge.
  - On each pclk rising edge with href high, phase 0 latches the high byte; phase 1 forms a pixel.
  - An href falling edge ends the line: column returns to 0 and line increments. A half pixel left at that point is discarded.
- Pixel output, when a pixel forms with column < H_ACTIVE:
  - If the output register is empty, or being accepted this same cycle, load it next cycle: pix_valid=1 and pix_addr=current address.
  - Otherwise set overflow and drop the pixel.
  - In both cases, column and address advance by one.
  - Pixels with column >= H_ACTIVE change nothing.
- Address: kept incrementally, with no multiplier. Reset to 0 at CAPTURE entry. At each line end, set to line*H_ACTIVE by accumulation.
- Handshake: pix_data and pix_addr hold stable while pix_valid && !pix_ready. pix_valid clears the cycle after acceptance unless a new pixel loads in the same cycle.
- Latency: pix_valid rises SYNC_STAGES+2 clk cycles after the cam_pclk rising edge that carries the second byte.
- overflow: set wins over a clear_overflow in the same cycle. Cleared only by clear_overflow or reset, and unaffected by FSM state.

Test Plan:
- Reset: hold reset_n low mid-CAPTURE, release. Required: all outputs 0, FSM in IDLE, busy=0, and no frame_done follows.
- Single frame: H_ACTIVE=4, V_ACTIVE=2, pix_ready=1, arm pulse, then vsync pulse and 2 lines of 8 bytes (0x01..0x10). Required: pixels 0x0102,0x0304,… at addresses 0..7, then frame_done exactly once, busy=0.
- Mid-frame arm: arm while vsync low and href active. Required: no pixels until after the next vsync falling edge; the first captured address is 0.
- Backpressure: hold pix_ready=0 across 2 pixels. Required: the first pixel is held stable, the second is dropped, overflow=1, and the next address skips to 2.
- Long and short lines:
  - 10-byte line with H_ACTIVE=4: only 4 pixels emitted.
  - 7-byte line: 3 pixels emitted, the odd byte is discarded, and the next line starts at address H_ACTIVE.
- Debounce: DEBOUNCE_CYCLES=8, shutter glitch high for 5 cycles, then high for 8 cycles. Required: the glitch causes no trigger; the stable press moves the FSM to WAIT_VS.

Source files
------------

// File: rtl/cam_capture_ctrl.sv
// Camera port capture sequencer: conditions pclk/vsync/href/data,
// packs byte pairs into RGB565 pixels and emits them with linear addresses.
module cam_capture_ctrl #(
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int ADDR_W          = 19,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cam_pclk,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    input  logic              shutter,
    input  logic              arm,
    input  logic              clear_overflow,
    output logic [15:0]       pix_data,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow
);

    localparam int COL_W  = $clog2(H_ACTIVE + 1);
    localparam int LINE_W = $clog2(V_ACTIVE + 1);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [COL_W-1:0]  H_COL   = COL_W'(H_ACTIVE);
    localparam logic [LINE_W-1:0] V_LAST  = LINE_W'(V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] H_ADDR  = ADDR_W'(H_ACTIVE);
    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        CAPTURE = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    // synchroniser chains and edge-detect delay flops
    logic [SYNC_STAGES-1:0]      pclk_sync_q, pclk_sync_d;
    logic [SYNC_STAGES-1:0]      vsync_sync_q, vsync_sync_d;
    logic [SYNC_STAGES-1:0]      href_sync_q, href_sync_d;
    logic [SYNC_STAGES-1:0]      sh_sync_q, sh_sync_d;
    logic [SYNC_STAGES:0][7:0]   data_sync_q, data_sync_d;
    logic                        pclk_dly_q, vsync_dly_q, href_dly_q;

    logic pclk_s, vsync_s, href_s, sh_s;
    logic pclk_rise, vsync_rise, vsync_fall, href_rise, href_fall;
    logic [7:0] byte_in;

    // debounce state
    logic            deb_q, deb_d;
    logic [DB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic            trigger;

    // sequencer and capture datapath
    state_t              state_q, state_d;
    logic                phase_q, phase_d;
    logic                phase_now;
    logic [7:0]          hi_byte_q, hi_byte_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                pend_q, pend_d;
    logic [15:0]         pend_data_q, pend_data_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic                frame_done_q, frame_done_d;

    // output register
    logic                pix_valid_q, pix_valid_d;
    logic [15:0]         pix_data_q, pix_data_d;
    logic [ADDR_W-1:0]   pix_addr_q, pix_addr_d;
    logic                overflow_q, overflow_d;

    assign pclk_s     = pclk_sync_q[SYNC_STAGES-1];
    assign vsync_s    = vsync_sync_q[SYNC_STAGES-1];
    assign href_s     = href_sync_q[SYNC_STAGES-1];
    assign sh_s       = sh_sync_q[SYNC_STAGES-1];
    assign byte_in    = data_sync_q[SYNC_STAGES];
    assign pclk_rise  = pclk_s & ~pclk_dly_q;
    assign vsync_rise = vsync_s & ~vsync_dly_q;
    assign vsync_fall = ~vsync_s & vsync_dly_q;
    assign href_rise  = href_s & ~href_dly_q;
    assign href_fall  = ~href_s & href_dly_q;

    // shift every camera/shutter input one stage down its chain
    always_comb begin
        pclk_sync_d  = (pclk_sync_q << 1) | SYNC_STAGES'(cam_pclk);
        vsync_sync_d = (vsync_sync_q << 1) | SYNC_STAGES'(cam_vsync);
        href_sync_d  = (href_sync_q << 1) | SYNC_STAGES'(cam_href);
        sh_sync_d    = (sh_sync_q << 1) | SYNC_STAGES'(shutter);
        data_sync_d  = {data_sync_q[SYNC_STAGES-1:0], cam_data};
    end

    // synchroniser and edge-detect registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pclk_sync_q  <= '0;
            vsync_sync_q <= '0;
            href_sync_q  <= '0;
            sh_sync_q    <= '0;
            data_sync_q  <= '0;
            pclk_dly_q   <= 1'b0;
            vsync_dly_q  <= 1'b0;
            href_dly_q   <= 1'b0;
        end else begin
            pclk_sync_q  <= pclk_sync_d;
            vsync_sync_q <= vsync_sync_d;
            href_sync_q  <= href_sync_d;
            sh_sync_q    <= sh_sync_d;
            data_sync_q  <= data_sync_d;
            pclk_dly_q   <= pclk_s;
            vsync_dly_q  <= vsync_s;
            href_dly_q   <= href_s;
        end
    end

    // shutter level flips after a full run of differing samples
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sh_s != deb_q) begin
            if (deb_cnt_q == DB_LAST) begin
                deb_d = ~deb_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    assign trigger = deb_d & ~deb_q;

    // debounce registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_q     <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // sequencer next state plus byte packing and line/column tracking
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        hi_byte_d    = hi_byte_q;
        col_d        = col_q;
        line_d       = line_q;
        addr_d       = addr_q;
        base_d       = base_q;
        pend_d       = 1'b0;
        pend_data_d  = pend_data_q;
        pend_addr_d  = pend_addr_q;
        frame_done_d = 1'b0;
        phase_now    = phase_q & ~href_rise;
        unique case (state_q)
            IDLE: begin
                if (trigger || arm) begin
                    state_d = WAIT_VS;
                end
            end
            WAIT_VS: begin
                if (vsync_fall) begin
                    state_d = CAPTURE;
                    phase_d = 1'b0;
                    col_d   = '0;
                    line_d  = '0;
                    addr_d  = '0;
                    base_d  = '0;
                end
            end
            CAPTURE: begin
                if (vsync_rise) begin
                    state_d = FLUSH;
                end else if (href_fall) begin
                    phase_d = 1'b0;
                    col_d   = '0;
                    line_d  = line_q + 1'b1;
                    base_d  = base_q + H_ADDR;
                    addr_d  = base_q + H_ADDR;
                    if (line_q == V_LAST) begin
                        state_d = FLUSH;
                    end
                end else begin
                    phase_d = phase_now;
                    if (pclk_rise && href_s) begin
                        if (!phase_now) begin
                            hi_byte_d = byte_in;
                            phase_d   = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            if (col_q < H_COL) begin
                                pend_d      = 1'b1;
                                pend_data_d = {hi_byte_q, byte_in};
                                pend_addr_d = addr_q;
                                col_d       = col_q + 1'b1;
                                addr_d      = addr_q + 1'b1;
                            end
                        end
                    end
                end
            end
            FLUSH: begin
                if (!pix_valid_q && !pend_q) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // sequencer and capture registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            phase_q      <= 1'b0;
            hi_byte_q    <= '0;
            col_q        <= '0;
            line_q       <= '0;
            addr_q       <= '0;
            base_q       <= '0;
            pend_q       <= 1'b0;
            pend_data_q  <= '0;
            pend_addr_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            hi_byte_q    <= hi_byte_d;
            col_q        <= col_d;
            line_q       <= line_d;
            addr_q       <= addr_d;
            base_q       <= base_d;
            pend_q       <= pend_d;
            pend_data_q  <= pend_data_d;
            pend_addr_q  <= pend_addr_d;
            frame_done_q <= frame_done_d;
        end
    end

    // load a new pixel when the slot frees up, otherwise flag the loss
    always_comb begin
        pix_valid_d = pix_valid_q & ~pix_ready;
        pix_data_d  = pix_data_q;
        pix_addr_d  = pix_addr_q;
        overflow_d  = overflow_q & ~clear_overflow;
        if (pend_q) begin
            if (!pix_valid_q || pix_ready) begin
                pix_valid_d = 1'b1;
                pix_data_d  = pend_data_q;
                pix_addr_d  = pend_addr_q;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    // output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            pix_addr_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
            pix_addr_q  <= pix_addr_d;
            overflow_q  <= overflow_d;
        end
    end

    assign pix_valid  = pix_valid_q;
    assign pix_data   = pix_data_q;
    assign pix_addr   = pix_addr_q;
    assign overflow   = overflow_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Bench for cam_capture_ctrl: drives camera frames, compares
// accepted pixels against a frame-level reference model.
`timescale 1ns/1ps
module tb_cam_capture_ctrl;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 8;
    localparam int DB = 8;
    localparam int SS = 2;

    logic          clk;
    logic          reset_n;
    logic          cam_pclk;
    logic          cam_vsync;
    logic          cam_href;
    logic [7:0]    cam_data;
    logic          shutter;
    logic          arm;
    logic          clear_overflow;
    logic [15:0]   pix_data;
    logic [AW-1:0] pix_addr;
    logic          pix_valid;
    logic          pix_ready;
    logic          busy;
    logic          frame_done;
    logic          overflow;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;

    logic [7:0]    fr_b [V][16];
    int            fr_len [V];
    logic [15:0]   exp_d[$];
    logic [AW-1:0] exp_a[$];
    logic [15:0]   got_d[$];
    logic [AW-1:0] got_a[$];

    longint t_pair = 0;
    longint t_first_valid = 0;
    logic   prev_valid = 1'b0;

    cam_capture_ctrl #(
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .ADDR_W(AW),
        .DEBOUNCE_CYCLES(DB),
        .SYNC_STAGES(SS)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cam_pclk(cam_pclk),
        .cam_vsync(cam_vsync),
        .cam_href(cam_href),
        .cam_data(cam_data),
        .shutter(shutter),
        .arm(arm),
        .clear_overflow(clear_overflow),
        .pix_data(pix_data),
        .pix_addr(pix_addr),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .busy(busy),
        .frame_done(frame_done),
        .overflow(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // record accepted pixels and frame_done pulses just before each edge
    always @(negedge clk) begin
        #4;
        if (reset_n && pix_valid && pix_ready) begin
            got_d.push_back(pix_data);
            got_a.push_back(pix_addr);
        end
        if (reset_n && frame_done) fd_cnt++;
        if (pix_valid && !prev_valid && t_first_valid == 0)
            t_first_valid = $time;
        prev_valid = pix_valid;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // reference: each line yields min(len/2, H) pixels at line*H + k
    function automatic void build_exp();
        int n;
        exp_d.delete();
        exp_a.delete();
        for (int l = 0; l < V; l++) begin
            n = fr_len[l] / 2;
            if (n > H) n = H;
            for (int k = 0; k < n; k++) begin
                exp_d.push_back({fr_b[l][2*k], fr_b[l][2*k+1]});
                exp_a.push_back(AW'(l * H + k));
            end
        end
    endfunction

    function automatic void clear_got();
        got_d.delete();
        got_a.delete();
    endfunction

    task automatic rand_frame();
        for (int l = 0; l < V; l++) begin
            fr_len[l] = int'($urandom_range(12, 1));
            for (int i = 0; i < 16; i++) fr_b[l][i] = 8'($urandom);
        end
    endtask

    task automatic pclk_cyc();
        cam_pclk = 1'b0;
        #20;
        cam_pclk = 1'b1;
        #20;
    endtask

    task automatic cam_frame();
        @(negedge clk);
        cam_vsync = 1'b1;
        repeat (3) pclk_cyc();
        cam_vsync = 1'b0;
        repeat (3) pclk_cyc();
        for (int l = 0; l < V; l++) begin
            for (int i = 0; i < fr_len[l]; i++) begin
                cam_pclk = 1'b0;
                cam_href = 1'b1;
                cam_data = fr_b[l][i];
                #20;
                cam_pclk = 1'b1;
                if (l == 0 && i == 1) t_pair = $time;
                #20;
            end
            cam_href = 1'b0;
            repeat (4) pclk_cyc();
        end
    endtask

    task automatic pulse_arm();
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic set_ready(input logic v);
        @(negedge clk);
        #2;
        pix_ready = v;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        chk(tag, busy, 0);
    endtask

    task automatic cmp_frame(input string tag);
        chk({tag, "_count"}, got_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
            chk($sformatf("%s_addr%0d", tag, i), got_a[i], exp_a[i]);
        end
    endtask

    task automatic run_capture(input string tag);
        clear_got();
        fd_cnt = 0;
        pulse_arm();
        cam_frame();
        wait_idle({tag, "_idle"});
        build_exp();
        cmp_frame(tag);
        chk({tag, "_done"}, fd_cnt, 1);
        chk({tag, "_ovf"}, overflow, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        cam_pclk = 1'b0;
        cam_vsync = 1'b0;
        cam_href = 1'b0;
        cam_data = 8'h00;
        shutter = 1'b0;
        arm = 1'b0;
        clear_overflow = 1'b0;
        pix_ready = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", pix_valid, 0);
        chk("rst_data", pix_data, 0);
        chk("rst_addr", pix_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_ovf", overflow, 0);

        // single directed frame, bytes 0x01..0x10
        for (int l = 0; l < V; l++) begin
            fr_len[l] = 8;
            for (int i = 0; i < 16; i++) fr_b[l][i] = 8'(l * 8 + i + 1);
        end
        clear_got();
        fd_cnt = 0;
        t_first_valid = 0;
        pulse_arm();
        chk("arm_busy", busy, 1);
        cam_frame();
        wait_idle("single_idle");
        build_exp();
        cmp_frame("single");
        chk("single_done", fd_cnt, 1);
        chk("single_lat", 32'(t_first_valid - t_pair), (SS + 2) * 10 + 4);

        // short line then long line
        fr_len[0] = 7;
        fr_len[1] = 10;
        run_capture("shortlong");

        // randomized frames
        for (int r = 0; r < 4; r++) begin
            rand_frame();
            run_capture($sformatf("rand%0d", r));
        end

        // arm in the middle of a frame already running
        rand_frame();
        fr_len[0] = 8;
        clear_got();
        fd_cnt = 0;
        fork
            cam_frame();
            begin
                repeat (36) @(negedge clk);
                arm = 1'b1;
                @(negedge clk);
                arm = 1'b0;
            end
        join
        chk("midarm_nopix", got_d.size(), 0);
        chk("midarm_wait", busy, 1);
        rand_frame();
        cam_frame();
        wait_idle("midarm_idle");
        build_exp();
        cmp_frame("midarm");
        chk("midarm_done", fd_cnt, 1);

        // backpressure across two pixels
        for (int l = 0; l < V; l++) begin
            fr_len[l] = 8;
            for (int i = 0; i < 16; i++) fr_b[l][i] = 8'($urandom);
        end
        build_exp();
        clear_got();
        fd_cnt = 0;
        set_ready(1'b0);
        pulse_arm();
        fork
            cam_frame();
            begin
                int n = 0;
                while (!pix_valid && n < 1000) begin
                    @(negedge clk);
                    n++;
                end
                chk("bp_wait", pix_valid, 1);
                repeat (10) @(negedge clk);
                chk("bp_hold_valid", pix_valid, 1);
                chk("bp_hold_data", pix_data, exp_d[0]);
                chk("bp_hold_addr", pix_addr, 0);
                chk("bp_ovf", overflow, 1);
                set_ready(1'b1);
            end
        join
        wait_idle("bp_idle");
        exp_d.delete(1);
        exp_a.delete(1);
        cmp_frame("bp");
        chk("bp_done", fd_cnt, 1);
        chk("bp_ovf_sticky", overflow, 1);
        @(negedge clk);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        chk("bp_ovf_clr", overflow, 0);

        // reset in the middle of capture
        rand_frame();
        fr_len[0] = 8;
        fd_cnt = 0;
        set_ready(1'b0);
        pulse_arm();
        fork
            cam_frame();
            begin
                repeat (60) @(negedge clk);
                chk("mid_busy", busy, 1);
                reset_n = 1'b0;
                repeat (3) @(negedge clk);
                reset_n = 1'b1;
                @(negedge clk);
                chk("mrst_valid", pix_valid, 0);
                chk("mrst_data", pix_data, 0);
                chk("mrst_addr", pix_addr, 0);
                chk("mrst_busy", busy, 0);
                chk("mrst_ovf", overflow, 0);
            end
        join
        set_ready(1'b1);
        repeat (40) @(negedge clk);
        chk("mrst_nodone", fd_cnt, 0);
        chk("mrst_idle", busy, 0);

        // shutter glitch then stable press
        @(negedge clk);
        shutter = 1'b1;
        repeat (5) @(negedge clk);
        shutter = 1'b0;
        repeat (20) @(negedge clk);
        chk("glitch_idle", busy, 0);
        shutter = 1'b1;
        repeat (SS + DB - 1) @(negedge clk);
        chk("press_early", busy, 0);
        @(negedge clk);
        chk("press_trig", busy, 1);
        rand_frame();
        clear_got();
        fd_cnt = 0;
        cam_frame();
        wait_idle("press_idle");
        build_exp();
        cmp_frame("press");
        chk("press_done", fd_cnt, 1);
        shutter = 1'b0;
        repeat (30) @(negedge clk);
        chk("release_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
